// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and timing helper
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    function automatic int pulse_width(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous FIFO with registered occupancy count
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [CNTW-1:0]       count_q;
    logic                  do_push;
    logic                  do_pop;

    assign full_o  = (count_q == CNTW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNTW'(1);
                2'b01:   count_q <= count_q - CNTW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - buffered UART transmitter, start/data/stop framing
import uart_pkg::*;

module uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 115_200,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ena,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_signal,
    output logic                  tx_busy
);
    localparam int PW = pulse_width(CLK_FREQ, BAUD_RATE);
    localparam int CW = $clog2(STOP_BITS * PW) + 1;
    localparam int BW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] BIT_LOAD  = CW'(PW - 1);
    localparam logic [CW-1:0] STOP_LOAD = CW'(STOP_BITS * PW - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);

    tx_state_t             state_q;
    logic [CW-1:0]         clk_cnt_q;
    logic [BW-1:0]         bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  tx_q;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  push;
    logic                  pop;
    logic                  cnt_done;

    assign cnt_done  = (clk_cnt_q == '0);
    assign tx_ready  = ena && !fifo_full;
    assign push      = tx_valid && tx_ready;
    // Pop from IDLE, or on the last stop cycle so frames run back-to-back.
    assign pop       = ena && !fifo_empty &&
                       ((state_q == TX_IDLE) || ((state_q == TX_STOP) && cnt_done));
    assign tx_signal = tx_q;
    assign tx_busy   = (state_q != TX_IDLE) || !fifo_empty;

    uart_tx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (tx_data),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= TX_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else if (ena) begin
            case (state_q)
                TX_IDLE: begin
                    if (pop) begin
                        shift_q   <= fifo_rdata;
                        clk_cnt_q <= BIT_LOAD;
                        state_q   <= TX_START;
                        tx_q      <= 1'b0;
                    end
                end
                TX_START: begin
                    if (cnt_done) begin
                        state_q   <= TX_DATA;
                        clk_cnt_q <= BIT_LOAD;
                        bit_cnt_q <= '0;
                        tx_q      <= shift_q[0];
                    end else begin
                        clk_cnt_q <= clk_cnt_q - CW'(1);
                    end
                end
                TX_DATA: begin
                    if (cnt_done) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q   <= TX_STOP;
                            clk_cnt_q <= STOP_LOAD;
                            tx_q      <= 1'b1;
                        end else begin
                            shift_q   <= shift_q >> 1;
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                            clk_cnt_q <= BIT_LOAD;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q - CW'(1);
                    end
                end
                TX_STOP: begin
                    if (cnt_done) begin
                        if (pop) begin
                            shift_q   <= fifo_rdata;
                            clk_cnt_q <= BIT_LOAD;
                            state_q   <= TX_START;
                            tx_q      <= 1'b0;
                        end else begin
                            state_q   <= TX_IDLE;
                            tx_q      <= 1'b1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q <= TX_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       ena = 1'b1;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_valid2;
    logic       tx_ready, tx_signal, tx_busy;
    logic       tx_ready2, tx_signal2, tx_busy2;

    bit         tog = 1'b0;
    int         ph  = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    logic [7:0] burst [6] = '{8'h00, 8'hFF, 8'h55, 8'h0F, 8'h80, 8'h01};

    uart_tx #(.CLK_FREQ(1000), .BAUD_RATE(100)) dut (
        .clk (clk), .reset (reset), .ena (ena),
        .tx_data (tx_data), .tx_valid (tx_valid), .tx_ready (tx_ready),
        .tx_signal (tx_signal), .tx_busy (tx_busy)
    );

    uart_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .STOP_BITS(2)) dut2 (
        .clk (clk), .reset (reset), .ena (ena),
        .tx_data (tx_data), .tx_valid (tx_valid2), .tx_ready (tx_ready2),
        .tx_signal (tx_signal2), .tx_busy (tx_busy2)
    );

    always #5 clk = ~clk;

    // ena pattern changes just after posedge so it is stable at negedge sampling.
    always @(posedge clk) begin
        #1;
        if (tog) begin
            ph  = (ph == 2) ? 0 : ph + 1;
            ena = (ph == 0);
        end else begin
            ena = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic line(input bit sel);
        return sel ? tx_signal2 : tx_signal;
    endfunction

    task automatic push(input bit sel, input logic [7:0] d);
        int n = 0;
        tx_data = d;
        if (sel) tx_valid2 = 1'b1; else tx_valid = 1'b1;
        while (((sel ? tx_ready2 : tx_ready) !== 1'b1) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("push_wait", 32'(n < 1000), 32'd1);
        @(negedge clk);
        tx_valid  = 1'b0;
        tx_valid2 = 1'b0;
    endtask

    task automatic recv(input bit sel, input int cpb, input int nstop, input logic [7:0] exp,
                        input string tag, output int waited, output logic busy_last);
        int         len;
        int         errs;
        int         idx;
        logic       lvl;
        logic       want;
        logic [7:0] got;
        len       = (1 + 8 + nstop) * cpb;
        errs      = 0;
        got       = 8'h00;
        busy_last = 1'bx;
        waited    = 0;
        while (line(sel) !== 1'b0 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_found"}, 32'(waited < 3000), 32'd1);
        for (int c = 0; c < len; c++) begin
            idx = c / cpb;
            lvl = line(sel);
            if (idx == 0)      want = 1'b0;
            else if (idx <= 8) want = exp[idx-1];
            else               want = 1'b1;
            if (lvl !== want) errs++;
            if (idx >= 1 && idx <= 8 && (c % cpb) == cpb / 2) got[idx-1] = lvl;
            if (c == len - 1) busy_last = sel ? tx_busy2 : tx_busy;
            @(negedge clk);
        end
        check({tag, "_shape"}, 32'(errs), 32'd0);
        check({tag, "_data"}, 32'(got), 32'(exp));
    endtask

    initial begin
        int   w;
        int   errs;
        logic bl;

        reset     = 1'b1;
        tx_valid  = 1'b1;
        tx_valid2 = 1'b0;
        tx_data   = 8'hEE;
        repeat (3) begin
            @(negedge clk);
            check("rst_line", 32'(tx_signal), 32'd1);
            check("rst_busy", 32'(tx_busy), 32'd0);
        end
        reset    = 1'b0;
        tx_valid = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(tx_busy), 32'd0);
        check("post_rst_ready", 32'(tx_ready), 32'd1);
        check("post_rst_line", 32'(tx_signal), 32'd1);
        check("post_rst_busy2", 32'(tx_busy2), 32'd0);

        // Single byte 0xA5
        push(1'b0, 8'hA5);
        check("a5_line_after_accept", 32'(tx_signal), 32'd1);
        recv(1'b0, 10, 1, 8'hA5, "a5", w, bl);
        check("a5_latency", 32'(w), 32'd1);
        check("a5_busy_last", 32'(bl), 32'd1);
        check("a5_busy_drop", 32'(tx_busy), 32'd0);

        // Burst with tx_valid held
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    int n = 0;
                    tx_data  = burst[i];
                    tx_valid = 1'b1;
                    while (tx_ready !== 1'b1 && n < 1000) begin
                        @(negedge clk);
                        n++;
                    end
                    check("burst_push_wait", 32'(n < 1000), 32'd1);
                    @(negedge clk);
                    if (i == 4) check("burst_full_ready", 32'(tx_ready), 32'd0);
                end
                tx_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    int   wk;
                    logic bk;
                    recv(1'b0, 10, 1, burst[k], "burst", wk, bk);
                    if (k > 0) check("burst_gap", 32'(wk), 32'd0);
                end
            end
        join
        check("burst_busy_end", 32'(tx_busy), 32'd0);

        // Two stop bits on the second instance
        push(1'b1, 8'h3C);
        recv(1'b1, 10, 2, 8'h3C, "stop2", w, bl);
        check("stop2_latency", 32'(w), 32'd1);
        check("stop2_busy_last", 32'(bl), 32'd1);
        check("stop2_busy_drop", 32'(tx_busy2), 32'd0);

        // ena high one cycle in three
        tog = 1'b1;
        repeat (3) @(negedge clk);
        fork
            begin
                push(1'b0, 8'h96);
                recv(1'b0, 30, 1, 8'h96, "ena3", w, bl);
            end
            begin
                errs = 0;
                for (int j = 0; j < 60; j++) begin
                    @(negedge clk);
                    if (ena === 1'b0 && tx_ready !== 1'b0) errs++;
                end
                check("ena_low_ready", 32'(errs), 32'd0);
            end
        join
        tog = 1'b0;
        repeat (3) @(negedge clk);
        check("ena3_busy_end", 32'(tx_busy), 32'd0);

        // Reset mid-frame with two bytes queued
        push(1'b0, 8'h12);
        push(1'b0, 8'h34);
        push(1'b0, 8'h56);
        repeat (40) @(negedge clk);
        check("mid_line_low", 32'(tx_signal), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_line", 32'(tx_signal), 32'd1);
        check("mid_rst_busy", 32'(tx_busy), 32'd0);
        check("mid_rst_ready", 32'(tx_ready), 32'd1);
        reset = 1'b0;
        errs = 0;
        for (int j = 0; j < 300; j++) begin
            @(negedge clk);
            if (tx_signal !== 1'b1 || tx_busy !== 1'b0) errs++;
        end
        check("mid_rst_quiet", 32'(errs), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter; the transmit-side counterpart of the team's UART receiver, so the two form a complete link on the board.
- Accepts bytes over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each byte as 8N1 by default (1 start, DATA_WIDTH data bits LSB first, STOP_BITS stop bits) on the tx_signal line.
- Uses the same clk/ena timebase as the receiver, so a loopback of tx_signal to rx_signal round-trips the data.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- BAUD_RATE, 115_200, line rate in bits/s.
- CLK_FREQ, 50_000_000, clk frequency in Hz.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- FIFO_DEPTH, 4, input buffer entries; power of two, at least 2.
- Derived: PULSE_WIDTH = CLK_FREQ/BAUD_RATE enabled cycles per bit (integer division).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- ena  in  1  clock enable; all state frozen when low.
- tx_data  in  DATA_WIDTH  byte to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  block can accept a byte; equals ena && !fifo_full.
- tx_signal  out  1  serial line; idle high; registered output.
- tx_busy  out  1  high while a frame is on the line or the FIFO is non-empty.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset values while reset is high, and on the first cycle after it drops:
  - tx_signal=1, tx_busy=0, FIFO empty, FSM in IDLE.
  - tx_ready=ena.
  - Reset dominates ena. Reset mid-frame aborts the frame immediately: the line returns high on the next edge and FIFO contents are discarded.
- Handshake:
  - A byte is accepted on a posedge where ena && tx_valid && tx_ready.
  - FIFO write pointer advances with wrap-around at FIFO_DEPTH.
  - While full, tx_ready=0 and tx_valid is ignored.
  - tx_data must be held only during the accepting cycle.
- Simultaneous push and pop on a full FIFO: not possible, since a full FIFO drives tx_ready low.
- Simultaneous push and pop on a non-full FIFO: both occur; count is unchanged.
- Push into an empty FIFO while the FSM is IDLE: the byte is popped on the following enabled cycle. Input-to-start-bit latency is 2 enabled cycles.
- FSM states (shared enum), with a bit counter bit_cnt and a clock counter clk_cnt counting PULSE_WIDTH-1 down to 0:
  - IDLE: tx_signal=1. If FIFO non-empty, pop into shift_reg, load clk_cnt, go to START.
  - START: tx_signal=0 for PULSE_WIDTH enabled cycles, then go to DATA with bit_cnt=0.
  - DATA: tx_signal=shift_reg[0] for PULSE_WIDTH cycles per bit, shifting right after each bit. After bit DATA_WIDTH-1, go to STOP.
  - STOP: tx_signal=1 for STOP_BITS*PULSE_WIDTH cycles. At the final cycle: if FIFO non-empty, pop and go directly to START (zero idle gap between frames); else go to IDLE.
- tx_signal is registered from the next-state value, so its level changes coincide with the state transitions.
- Frame length: exactly (2+DATA_WIDTH-1+STOP_BITS)*PULSE_WIDTH enabled cycles, i.e. (1+DATA_WIDTH+STOP_BITS)*PULSE_WIDTH.
- ena low:
  - counters, FSM, FIFO and tx_signal hold;
  - no push or pop;
  - tx_ready=0.
- Counter widths: clk_cnt is $clog2(STOP_BITS*PULSE_WIDTH)+1 bits; bit_cnt is $clog2(DATA_WIDTH)+1 bits; no overflow is possible.
- tx_busy = (state!=IDLE) || !fifo_empty.

Decomposition:
- Package uart_pkg:
  - tx state enum (IDLE, START, DATA, STOP, 2-bit);
  - pulse_width(clk_freq, baud) function;
  - the receiver's state enum moved here too.
- Sub-module uart_tx_fifo: synchronous FIFO with push/pop/full/empty and a registered count. It is reusable by a later RX-side buffer.
- The FSM and serializer live in uart_tx.

Test Plan:
- Bench overrides CLK_FREQ=1000 and BAUD_RATE=100, giving PULSE_WIDTH=10; ena=1 unless stated.
- Reset: hold reset 3 cycles with tx_valid=1 -> tx_signal=1, tx_busy=0, no byte accepted; tx_ready=1 after release.
- Single byte 0xA5 -> start bit 2 cycles after accept; line reads 0,1,0,1,0,0,1,0,1,1, each level lasting 10 cycles; tx_busy drops on the cycle after the stop bit ends; total 100 cycles.
- Burst of 6 bytes 0x00,0xFF,0x55,0x0F,0x80,0x01 with tx_valid held -> tx_ready drops after the FIFO holds 4 plus 1 in flight; frames are back-to-back with no idle gap; a bench-side receiver decodes all 6 in order.
- STOP_BITS=2, byte 0x3C -> stop high for 20 cycles; frame is 110 cycles.
- ena toggling 1-of-3 cycles during byte 0x96 -> every bit lasts 30 clk cycles; tx_ready=0 on ena-low cycles; data is correct.
- Reset asserted mid-DATA of 0x12 with 2 bytes queued -> tx_signal=1 on the next edge, FIFO empty, tx_busy=0, and no further frames are sent.
